// File: rtl/ps2_spectrum_kbd.sv
// rtl/ps2_spectrum_kbd.sv - PS/2 Set-2 receiver and ZX Spectrum 8x5 keyboard matrix
module ps2_spectrum_kbd #(
  parameter int TIMEOUT = 16383
) (
  input  logic       clk_sys,
  input  logic       reset_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic [7:0] addr_hi,
  output logic [4:0] key_data,
  output logic       scan_valid,
  output logic [7:0] scan_code,
  output logic       frame_err,
  output logic       key_reset,
  output logic       key_nmi
);

  typedef enum logic {ST_IDLE, ST_SKIP} dec_state_t;

  logic [1:0]  clk_sync, data_sync;
  logic        clk_prev;
  logic [3:0]  bit_cnt;
  logic [9:0]  shreg;
  logic [14:0] tmr;
  dec_state_t  state;
  logic [2:0]  skip_cnt;
  logic        ext, brk;
  logic [39:0] kf;
  logic        lshift, rshift, e_ss, cur_l, cur_d, cur_u, cur_r, bksp;

  logic        fall, frame_done, frame_ok, make;
  logic [7:0]  rx_byte;
  logic [5:0]  idx;
  logic [7:0][4:0] pressed;

  // Maps a plain scancode to its matrix position (row*5 + column); 63 means unmapped
  function automatic logic [5:0] map_idx(input logic [7:0] c);
    case (c)
      8'h1A: map_idx = 6'd1;  8'h22: map_idx = 6'd2;  8'h21: map_idx = 6'd3;  8'h2A: map_idx = 6'd4;
      8'h1C: map_idx = 6'd5;  8'h1B: map_idx = 6'd6;  8'h23: map_idx = 6'd7;  8'h2B: map_idx = 6'd8;
      8'h34: map_idx = 6'd9;  8'h15: map_idx = 6'd10; 8'h1D: map_idx = 6'd11; 8'h24: map_idx = 6'd12;
      8'h2D: map_idx = 6'd13; 8'h2C: map_idx = 6'd14; 8'h16: map_idx = 6'd15; 8'h1E: map_idx = 6'd16;
      8'h26: map_idx = 6'd17; 8'h25: map_idx = 6'd18; 8'h2E: map_idx = 6'd19; 8'h45: map_idx = 6'd20;
      8'h46: map_idx = 6'd21; 8'h3E: map_idx = 6'd22; 8'h3D: map_idx = 6'd23; 8'h36: map_idx = 6'd24;
      8'h4D: map_idx = 6'd25; 8'h44: map_idx = 6'd26; 8'h43: map_idx = 6'd27; 8'h3C: map_idx = 6'd28;
      8'h35: map_idx = 6'd29; 8'h5A: map_idx = 6'd30; 8'h4B: map_idx = 6'd31; 8'h42: map_idx = 6'd32;
      8'h3B: map_idx = 6'd33; 8'h33: map_idx = 6'd34; 8'h29: map_idx = 6'd35; 8'h14: map_idx = 6'd36;
      8'h3A: map_idx = 6'd37; 8'h31: map_idx = 6'd38; 8'h32: map_idx = 6'd39;
      default: map_idx = 6'd63;
    endcase
  endfunction

  assign fall       = clk_prev & ~clk_sync[1];
  assign frame_done = fall && (bit_cnt == 4'd10);
  assign rx_byte    = shreg[8:1];
  // shreg[0]=start, shreg[8:1]=D0..D7, shreg[9]=parity; the stop bit is the live sample
  assign frame_ok   = ~shreg[0] & data_sync[1] & (^shreg[9:1]);
  assign make       = ~brk;
  assign idx        = map_idx(rx_byte);

  // Two-flop synchronisers plus the delayed clock used for falling-edge detection
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
      clk_prev  <= 1'b1;
    end else begin
      clk_sync  <= {clk_sync[0], ps2_clk};
      data_sync <= {data_sync[0], ps2_data};
      clk_prev  <= clk_sync[1];
    end
  end

  // Frame receiver, timeout, and make/break decoder acting on each accepted byte
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      bit_cnt    <= '0;
      shreg      <= '0;
      tmr        <= '0;
      scan_valid <= 1'b0;
      scan_code  <= '0;
      frame_err  <= 1'b0;
      state      <= ST_IDLE;
      skip_cnt   <= '0;
      ext        <= 1'b0;
      brk        <= 1'b0;
      kf         <= '0;
      lshift     <= 1'b0;
      rshift     <= 1'b0;
      e_ss       <= 1'b0;
      cur_l      <= 1'b0;
      cur_d      <= 1'b0;
      cur_u      <= 1'b0;
      cur_r      <= 1'b0;
      bksp       <= 1'b0;
      key_reset  <= 1'b0;
      key_nmi    <= 1'b0;
    end else begin
      scan_valid <= 1'b0;
      frame_err  <= 1'b0;
      if (frame_done) begin
        bit_cnt <= '0;
        tmr     <= '0;
        if (frame_ok) begin
          scan_valid <= 1'b1;
          scan_code  <= rx_byte;
          if (state == ST_SKIP) begin
            if (skip_cnt == 3'd1) state <= ST_IDLE;
            skip_cnt <= skip_cnt - 3'd1;
          end else begin
            case (rx_byte)
              8'hE0: ext <= 1'b1;
              8'hF0: brk <= 1'b1;
              8'hE1: begin
                state    <= ST_SKIP;
                skip_cnt <= 3'd7;
                ext      <= 1'b0;
                brk      <= 1'b0;
              end
              default: begin
                ext <= 1'b0;
                brk <= 1'b0;
                if (ext) begin
                  case (rx_byte)
                    8'h14: e_ss  <= make;
                    8'h6B: cur_l <= make;
                    8'h72: cur_d <= make;
                    8'h75: cur_u <= make;
                    8'h74: cur_r <= make;
                    default: ;
                  endcase
                end else begin
                  case (rx_byte)
                    8'h12: lshift    <= make;
                    8'h59: rshift    <= make;
                    8'h66: bksp      <= make;
                    8'h78: key_reset <= make;
                    8'h07: key_nmi   <= make;
                    default: if (idx < 6'd40) kf[idx] <= make;
                  endcase
                end
              end
            endcase
          end
        end else begin
          frame_err <= 1'b1;
          ext       <= 1'b0;
          brk       <= 1'b0;
        end
      end else if (fall) begin
        shreg   <= {data_sync[1], shreg[9:1]};
        bit_cnt <= bit_cnt + 4'd1;
        tmr     <= '0;
      end else if (bit_cnt == 4'd0) begin
        tmr <= '0;
      end else if (tmr == 15'(TIMEOUT)) begin
        bit_cnt   <= '0;
        frame_err <= 1'b1;
      end else begin
        tmr <= tmr + 15'd1;
      end
    end
  end

  // Pressed matrix: plain key flags ORed with shift, composite and extended flags
  always_comb begin
    for (int i = 0; i < 8; i++) pressed[i] = kf[i*5 +: 5];
    pressed[0][0] = kf[0] | lshift | rshift | cur_l | cur_d | cur_u | cur_r | bksp;
    pressed[7][1] = kf[36] | e_ss;
    pressed[3][4] = kf[19] | cur_l;
    pressed[4][0] = kf[20] | bksp;
    pressed[4][2] = kf[22] | cur_r;
    pressed[4][3] = kf[23] | cur_u;
    pressed[4][4] = kf[24] | cur_d;
  end

  // Active-low read of every row selected by a low address bit
  always_comb begin
    key_data = 5'h1F;
    for (int i = 0; i < 8; i++)
      if (!addr_hi[i]) key_data = key_data & ~pressed[i];
  end

endmodule

// File: tb/tb_ps2_spectrum_kbd.sv
// tb/tb_ps2_spectrum_kbd.sv - directed bench for ps2_spectrum_kbd
module tb_ps2_spectrum_kbd;
  localparam int TIMEOUT = 16383;
  localparam int HALF = 10;

  logic       clk_sys = 1'b0;
  logic       reset_n;
  logic       ps2_clk, ps2_data;
  logic [7:0] addr_hi;
  logic [4:0] key_data;
  logic       scan_valid, frame_err, key_reset, key_nmi;
  logic [7:0] scan_code;

  int n_vec = 0;
  int n_bad = 0;
  int sv_cnt = 0;
  int err_cnt = 0;

  ps2_spectrum_kbd #(.TIMEOUT(TIMEOUT)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .addr_hi(addr_hi), .key_data(key_data), .scan_valid(scan_valid),
    .scan_code(scan_code), .frame_err(frame_err), .key_reset(key_reset), .key_nmi(key_nmi)
  );

  always #5 clk_sys = ~clk_sys;

  always @(negedge clk_sys) begin
    if (scan_valid === 1'b1) sv_cnt++;
    if (frame_err === 1'b1) err_cnt++;
  end

  function automatic logic [10:0] mk_frame(input logic [7:0] b, input logic bad_par);
    mk_frame = {1'b1, ~(^b) ^ bad_par, b, 1'b0};
  endfunction

  task automatic ps2_bits(input logic [10:0] f, input int n);
    for (int i = 0; i < n; i++) begin
      ps2_data = f[i];
      repeat (HALF) @(negedge clk_sys);
      ps2_clk = 1'b0;
      if (i < n - 1) begin
        repeat (HALF) @(negedge clk_sys);
        ps2_clk = 1'b1;
      end
    end
  endtask

  task automatic ps2_tail();
    repeat (HALF) @(negedge clk_sys);
    ps2_clk = 1'b1;
    repeat (2 * HALF) @(negedge clk_sys);
  endtask

  task automatic send_byte(input logic [7:0] b);
    ps2_bits(mk_frame(b, 1'b0), 11);
    ps2_tail();
  endtask

  task automatic test_reset();
    addr_hi = 8'h00;
    @(negedge clk_sys);
    n_vec++; if (key_data !== 5'h1F) begin n_bad++; $display("FAIL reset_key_data got %h want 1f", key_data); end
    n_vec++; if (scan_valid !== 1'b0) begin n_bad++; $display("FAIL reset_scan_valid got %b want 0", scan_valid); end
    n_vec++; if (scan_code !== 8'h00) begin n_bad++; $display("FAIL reset_scan_code got %h want 00", scan_code); end
    n_vec++; if (frame_err !== 1'b0) begin n_bad++; $display("FAIL reset_frame_err got %b want 0", frame_err); end
    n_vec++; if (key_reset !== 1'b0 || key_nmi !== 1'b0) begin n_bad++; $display("FAIL reset_fkeys got %b%b want 00", key_reset, key_nmi); end
  endtask

  task automatic test_make_break();
    int sv0;
    logic [3:0] seen;
    sv0 = sv_cnt;
    ps2_bits(mk_frame(8'h1C, 1'b0), 11);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_sys);
      seen[k] = scan_valid;
      if (k == 2) begin
        n_vec++; if (scan_code !== 8'h1C) begin n_bad++; $display("FAIL make_scan_code got %h want 1c", scan_code); end
      end
    end
    n_vec++; if (seen !== 4'b0100) begin n_bad++; $display("FAIL make_latency got %b want 0100", seen); end
    ps2_tail();
    addr_hi = 8'hFD; @(negedge clk_sys);
    n_vec++; if (key_data !== 5'h1E) begin n_bad++; $display("FAIL a_make got %h want 1e", key_data); end
    send_byte(8'hF0); send_byte(8'h1C);
    @(negedge clk_sys);
    n_vec++; if (key_data !== 5'h1F) begin n_bad++; $display("FAIL a_break got %h want 1f", key_data); end
    n_vec++; if (sv_cnt - sv0 !== 3) begin n_bad++; $display("FAIL make_break_pulses got %0d want 3", sv_cnt - sv0); end
    n_vec++; if (scan_code !== 8'h1C) begin n_bad++; $display("FAIL scan_code_held got %h want 1c", scan_code); end
  endtask

  task automatic test_cursor();
    send_byte(8'hE0); send_byte(8'h75);
    addr_hi = 8'hFE; @(negedge clk_sys);
    n_vec++; if (key_data !== 5'h1E) begin n_bad++; $display("FAIL up_cs got %h want 1e", key_data); end
    addr_hi = 8'hEF; @(negedge clk_sys);
    n_vec++; if (key_data !== 5'h17) begin n_bad++; $display("FAIL up_7 got %h want 17", key_data); end
    send_byte(8'h12);
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
    addr_hi = 8'hFE; @(negedge clk_sys);
    n_vec++; if (key_data !== 5'h1E) begin n_bad++; $display("FAIL shift_keeps_cs got %h want 1e", key_data); end
    addr_hi = 8'hEF; @(negedge clk_sys);
    n_vec++; if (key_data !== 5'h1F) begin n_bad++; $display("FAIL up_released got %h want 1f", key_data); end
    send_byte(8'hF0); send_byte(8'h12);
    addr_hi = 8'hFE; @(negedge clk_sys);
    n_vec++; if (key_data !== 5'h1F) begin n_bad++; $display("FAIL shift_released got %h want 1f", key_data); end
  endtask

  task automatic test_parity();
    int sv0, e0;
    sv0 = sv_cnt; e0 = err_cnt;
    ps2_bits(mk_frame(8'h29, 1'b1), 11); ps2_tail();
    addr_hi = 8'h7F; @(negedge clk_sys);
    n_vec++; if (err_cnt - e0 !== 1) begin n_bad++; $display("FAIL parity_err got %0d want 1", err_cnt - e0); end
    n_vec++; if (sv_cnt - sv0 !== 0) begin n_bad++; $display("FAIL parity_no_valid got %0d want 0", sv_cnt - sv0); end
    n_vec++; if (key_data !== 5'h1F) begin n_bad++; $display("FAIL parity_no_key got %h want 1f", key_data); end
    send_byte(8'h29);
    @(negedge clk_sys);
    n_vec++; if (key_data !== 5'h1E) begin n_bad++; $display("FAIL after_parity_space got %h want 1e", key_data); end
    send_byte(8'hF0); send_byte(8'h29);
  endtask

  task automatic test_timeout();
    int sv0, e0;
    sv0 = sv_cnt; e0 = err_cnt;
    ps2_bits(mk_frame(8'h45, 1'b0), 4);
    repeat (HALF) @(negedge clk_sys);
    ps2_clk = 1'b1;
    repeat (TIMEOUT + 10) @(negedge clk_sys);
    n_vec++; if (err_cnt - e0 !== 1) begin n_bad++; $display("FAIL timeout_err got %0d want 1", err_cnt - e0); end
    send_byte(8'h45);
    addr_hi = 8'hEF; @(negedge clk_sys);
    n_vec++; if (key_data !== 5'h1E) begin n_bad++; $display("FAIL after_timeout_0 got %h want 1e", key_data); end
    n_vec++; if (sv_cnt - sv0 !== 1) begin n_bad++; $display("FAIL timeout_valid_count got %0d want 1", sv_cnt - sv0); end
    send_byte(8'hF0); send_byte(8'h45);
  endtask

  task automatic test_pause();
    logic [7:0] seq [8];
    seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
    send_byte(8'h15); send_byte(8'h16);
    addr_hi = 8'hF3; @(negedge clk_sys);
    n_vec++; if (key_data !== 5'h1E) begin n_bad++; $display("FAIL q_and_1 got %h want 1e", key_data); end
    for (int k = 0; k < 8; k++) send_byte(seq[k]);
    addr_hi = 8'h00; @(negedge clk_sys);
    n_vec++; if (key_data !== 5'h1E) begin n_bad++; $display("FAIL pause_no_change got %h want 1e", key_data); end
    n_vec++; if (key_reset !== 1'b0) begin n_bad++; $display("FAIL pause_no_reset got %b want 0", key_reset); end
    send_byte(8'h78);
    @(negedge clk_sys);
    n_vec++; if (key_reset !== 1'b1) begin n_bad++; $display("FAIL f11_reset got %b want 1", key_reset); end
    send_byte(8'h07);
    @(negedge clk_sys);
    n_vec++; if (key_nmi !== 1'b1) begin n_bad++; $display("FAIL f12_nmi got %b want 1", key_nmi); end
  endtask

  task automatic test_back_to_back();
    send_byte(8'h66);
    addr_hi = 8'hEE; @(negedge clk_sys);
    n_vec++; if (key_data !== 5'h1E) begin n_bad++; $display("FAIL bksp got %h want 1e", key_data); end
    send_byte(8'h1A);
    addr_hi = 8'hFE; @(negedge clk_sys);
    n_vec++; if (key_data !== 5'h1C) begin n_bad++; $display("FAIL cs_z got %h want 1c", key_data); end
    send_byte(8'hF0); send_byte(8'h66);
    @(negedge clk_sys);
    n_vec++; if (key_data !== 5'h1D) begin n_bad++; $display("FAIL z_only got %h want 1d", key_data); end
  endtask

  task automatic test_reset_mid();
    int e0;
    e0 = err_cnt;
    ps2_bits(mk_frame(8'h29, 1'b0), 3);
    addr_hi = 8'h00;
    reset_n = 1'b0;
    #1;
    n_vec++; if (key_data !== 5'h1F) begin n_bad++; $display("FAIL midreset_keys got %h want 1f", key_data); end
    n_vec++; if (key_reset !== 1'b0 || key_nmi !== 1'b0) begin n_bad++; $display("FAIL midreset_fkeys got %b%b want 00", key_reset, key_nmi); end
    n_vec++; if (scan_code !== 8'h00) begin n_bad++; $display("FAIL midreset_code got %h want 00", scan_code); end
    ps2_clk = 1'b1; ps2_data = 1'b1;
    repeat (5) @(negedge clk_sys);
    reset_n = 1'b1;
    repeat (5) @(negedge clk_sys);
    send_byte(8'h5A);
    addr_hi = 8'hBF; @(negedge clk_sys);
    n_vec++; if (key_data !== 5'h1E) begin n_bad++; $display("FAIL enter_after_reset got %h want 1e", key_data); end
    n_vec++; if (err_cnt - e0 !== 0) begin n_bad++; $display("FAIL midreset_no_err got %0d want 0", err_cnt - e0); end
  endtask

  initial begin
    reset_n = 1'b0; ps2_clk = 1'b1; ps2_data = 1'b1; addr_hi = 8'hFF;
    repeat (5) @(negedge clk_sys);
    test_reset();
    reset_n = 1'b1;
    repeat (5) @(negedge clk_sys);
    test_make_break();
    test_cursor();
    test_parity();
    test_timeout();
    test_pause();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/ps2_spectrum_kbd.md
Name: ps2_spectrum_kbd

Overview:
- Consumes the emulated PS/2 keyboard stream (ps2_kbd_clk / ps2_kbd_data) from the HPS I/O block.
- Deframes Set-2 scancodes and tracks make/break state per key, then presents the 8x5 ZX Spectrum keyboard matrix to the ULA port-#FE read path.
- Also raises reset/NMI request levels from function keys.

Parameters:
- TIMEOUT, 16383, clk_sys cycles without a PS/2 falling edge, mid-frame, before the frame is aborted (counter width 15 bits).

Ports:
- clk_sys  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- ps2_clk  in  1  PS/2 clock from HPS I/O; idles high; asynchronous to the receiver, so it is synchronised
- ps2_data  in  1  PS/2 data from HPS I/O
- addr_hi  in  8  CPU A15..A8; bit i low selects matrix row i
- key_data  out  5  matrix read, active-low D4..D0
- scan_valid  out  1  one-cycle pulse when a frame is accepted
- scan_code  out  8  last accepted byte; valid while scan_valid is high and held afterwards
- frame_err  out  1  one-cycle pulse on a bad start, parity or stop bit, or on timeout
- key_reset  out  1  level, high while F11 (78) is held
- key_nmi  out  1  level, high while F12 (07) is held

Behaviour:
- Reset (async, reset_n low) sets:
  - key_data=1F, scan_valid=0, scan_code=00, frame_err=0, key_reset=0, key_nmi=0
  - all key flags cleared, prefix flags cleared, bit counter=0, timeout counter=0
- Synchroniser and edge detect:
  - ps2_clk and ps2_data each pass through 2 flops.
  - A falling edge is detected on the synchronised clock (previous 1, current 0).
- Receiver: 11-bit shift on each falling edge: start, D0..D7 LSB-first, odd parity, stop.
  - Bit counter runs 0..10. On edge 11:
    - Frame accepted if start==0, stop==1 and XOR(D7..D0, parity)==1.
    - Accepted: scan_valid=1 and scan_code=byte on the next cycle. That is 1 cycle after the stop-bit edge is detected, 3 clk_sys after the raw edge.
    - Rejected: frame_err pulses; prefix flags are cleared; key flags are untouched.
  - Timeout counter clears on every falling edge and increments while the bit counter is nonzero.
    - At TIMEOUT: bit counter=0 and frame_err pulses.
    - The counter saturates and does not wrap.
    - While the bit counter is 0 the timer is held at 0.
- Decoder state machine (acts on accepted bytes):
  - IDLE:
    - E0 -> set ext.
    - F0 -> set brk.
    - E1 -> SKIP with skip count 7.
    - Any other byte -> apply the key (set flag if brk=0, clear if brk=1), then clear ext and brk.
  - SKIP: decrement on each accepted byte; return to IDLE when the count reaches 0. Used to swallow the Pause sequence.
  - Break for a key not pressed: no effect.
  - Unmapped codes: consumed; prefixes cleared.
- Key map, non-extended, rows listed D0..D4:
  - row0: CS(12 or 59), Z 1A, X 22, C 21, V 2A
  - row1: A 1C, S 1B, D 23, F 2B, G 34
  - row2: Q 15, W 1D, E 24, R 2D, T 2C
  - row3: 1 16, 2 1E, 3 26, 4 25, 5 2E
  - row4: 0 45, 9 46, 8 3E, 7 3D, 6 36
  - row5: P 4D, O 44, I 43, U 3C, Y 35
  - row6: Enter 5A, L 4B, K 42, J 3B, H 33
  - row7: Space 29, SS 14, M 3A, N 31, B 32
- Key map, extended:
  - E0 14 -> SS
  - Cursors: E0 6B -> CS+5, E0 72 -> CS+6, E0 75 -> CS+7, E0 74 -> CS+8
- Key map, composite: 66 (backspace) -> CS+0.
- Composites use their own flags. A matrix bit is pressed if any contributing flag is set, so releasing a cursor key while a real Shift is held keeps CS pressed.
- Left shift and right shift have separate flags; CS is their OR.
- key_data is combinational from registered state:
  - bit j = NOT( OR over rows i with addr_hi[i]==0 of pressed[i][j] ).
  - addr_hi=FF gives 1F.
  - Multiple low address bits give a wired-AND across the selected rows.
- Simultaneous events: a flag update and a key_data read in the same cycle show the old value; the new value appears the next cycle.
- reset_n asserted mid-frame aborts the frame; no frame_err is produced.

Test Plan:
- Send frame 1C (A make) -> scan_valid 1 cycle with scan_code=1C. addr_hi=FD gives key_data=1E. Then F0,1C -> key_data=1F.
- Send E0,75 (up) -> addr_hi=FE gives 1E and addr_hi=EF gives 17. Send 12 (Shift make), then E0,F0,75 -> addr_hi=FE still 1E.
- Frame byte 29 with parity bit flipped -> frame_err pulse, no scan_valid, addr_hi=7F gives 1F. Next good frame is decoded normally.
- Stop ps2_clk after 4 bits for TIMEOUT+10 cycles -> frame_err pulse, bit counter 0. Following full frame 45 decodes; addr_hi=EF gives 1E.
- Press Q (15) and 1 (16); addr_hi=F3 -> 1E. Send E1 14 77 E1 F0 14 F0 77 (Pause) -> no matrix change; next byte 78 -> key_reset=1.
- Assert reset_n low mid-frame with keys held -> all outputs at reset values immediately. Release, send 5A -> addr_hi=BF gives 1E.
